// File: rtl/multi_event_shaper.sv
// multi_event_shaper
// Per-channel low-cycle counters plus a round-robin scanner that turns each
// count into one result through a three-region shaping function: zero above
// HI_TH, square at or below LO_TH, halve in between. Results leave through a
// single tagged output register.
//
// Output handshake: a transfer happens on every rising edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_valid,
// out_ch and out_data hold their values. The register reloads whenever it is
// empty or its current result is being consumed in the same cycle.
module multi_event_shaper #(
    parameter int CH    = 4,
    parameter int W     = 8,
    parameter int LO_TH = 4,
    parameter int HI_TH = 16,
    parameter int SAT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [CH-1:0]         in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [$clog2(CH)-1:0] out_ch,
    output logic [W-1:0]          out_data,
    output logic [CH-1:0]         ovf
);

    localparam int CW = $clog2(CH);
    localparam logic [W-1:0]  LO_V    = W'(LO_TH);
    localparam logic [W-1:0]  HI_V    = W'(HI_TH);
    localparam logic [CW-1:0] PTR_MAX = CW'(CH - 1);

    logic [W-1:0]  cnt [CH];
    logic [CW-1:0] ptr;
    logic [W-1:0]  sel_cnt;
    logic [W-1:0]  shaped;
    logic          load;

    // Three-region shaping; the square is formed at double width, then truncated.
    function automatic logic [W-1:0] shape(input logic [W-1:0] c);
        logic [2*W-1:0] wide;
        logic [2*W-1:0] sq;
        wide = {{W{1'b0}}, c};
        sq   = wide * wide;
        if (c > HI_V)
            return '0;
        else if (c <= LO_V)
            return sq[W-1:0];
        else
            return c >> 1;
    endfunction

    // Pick the count under the scan pointer and shape it; this is the pre-edge value.
    always_comb begin
        sel_cnt = cnt[ptr];
        shaped  = shape(sel_cnt);
        load    = !out_valid || out_ready;
    end

    // Per-channel counters and sticky overflow flags; clr wins over en and in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
                ovf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (clr) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (en && !in[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
                        if (SAT == 0)
                            cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + W'(1);
                    end
                end
            end
        end
    end

    // Scanner and output register: load the next tagged result when the slot frees up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ch    <= ptr;
            out_data  <= shaped;
            ptr       <= (ptr == PTR_MAX) ? '0 : ptr + CW'(1);
        end
    end

endmodule

// File: tb/tb_multi_event_shaper.sv
// Bench for multi_event_shaper: two instances (wrapping and saturating
// counters) share one stimulus stream and are checked each cycle against a
// behavioural model written from the block's rules.
module tb_multi_event_shaper;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int LO   = 4;
    localparam int HI   = 16;
    localparam int MAXC = 255;

    logic          clk;
    logic          reset;
    logic          en;
    logic          clr;
    logic [CH-1:0] in_b;
    logic          rdy;

    logic          dv   [2];
    logic [1:0]    dch  [2];
    logic [W-1:0]  dd   [2];
    logic [CH-1:0] dovf [2];

    int checks;
    int failures;

    // model state, index 0 = wrapping instance, 1 = saturating instance
    int          m_cnt [2][CH];
    bit [CH-1:0] m_ovf [2];
    int          m_ptr [2];
    bit          m_v   [2];
    int          m_ch  [2];
    int          m_d   [2];

    multi_event_shaper #(.CH(CH), .W(W), .LO_TH(LO), .HI_TH(HI), .SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in(in_b), .out_ready(rdy),
        .out_valid(dv[0]), .out_ch(dch[0]), .out_data(dd[0]), .ovf(dovf[0])
    );

    multi_event_shaper #(.CH(CH), .W(W), .LO_TH(LO), .HI_TH(HI), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in(in_b), .out_ready(rdy),
        .out_valid(dv[1]), .out_ch(dch[1]), .out_data(dd[1]), .ovf(dovf[1])
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int shape(int c);
        if (c > HI) return 0;
        if (c <= LO) return (c * c) % (MAXC + 1);
        return c / 2;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CH; i++) m_cnt[k][i] = 0;
            m_ovf[k] = '0;
            m_ptr[k] = 0;
            m_v[k]   = 0;
            m_ch[k]  = 0;
            m_d[k]   = 0;
        end
    endtask

    // one rising edge of the model, using the inputs currently driven
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!m_v[k] || rdy) begin
                m_v[k]   = 1;
                m_ch[k]  = m_ptr[k];
                m_d[k]   = shape(m_cnt[k][m_ptr[k]]);
                m_ptr[k] = (m_ptr[k] + 1) % CH;
            end
            for (int i = 0; i < CH; i++) begin
                if (clr) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 0;
                end else if (en && !in_b[i]) begin
                    if (m_cnt[k][i] == MAXC) begin
                        m_ovf[k][i] = 1;
                        if (k == 0) m_cnt[k][i] = 0;
                    end else begin
                        m_cnt[k][i] = m_cnt[k][i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid[%0d]", k), int'(dv[k]), int'(m_v[k]));
            check($sformatf("ch[%0d]", k), int'(dch[k]), m_ch[k]);
            check($sformatf("data[%0d]", k), int'(dd[k]), m_d[k]);
            check($sformatf("ovf[%0d]", k), int'(dovf[k]), int'(m_ovf[k]));
        end
    endtask

    // drive inputs, take one edge, update model, compare 1ns after the edge
    task automatic step(input bit e, input bit c, input logic [CH-1:0] iv, input bit r);
        en   = e;
        clr  = c;
        in_b = iv;
        rdy  = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // idle with ready high until the model has just loaded channel target
    task automatic advance_to(input int target);
        int n;
        n = 0;
        while (m_ch[0] != target && n < 2 * CH) begin
            step(1, 0, 4'hF, 1);
            n++;
        end
        if (m_ch[0] != target) begin
            checks++;
            failures++;
            $display("FAIL advance_to timeout actual=%0d expected=%0d", m_ch[0], target);
        end
    endtask

    int hch;
    int hd;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        in_b     = 4'hF;
        rdy      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_valid", int'(dv[0]), 0);
        reset = 1'b0;

        // idle stream
        for (int t = 0; t < 12; t++) begin
            step(1, 0, 4'hF, 1);
            if (t == 0) begin
                check("first_valid", int'(dv[0]), 1);
                check("first_ch", int'(dch[0]), 0);
                check("first_data", int'(dd[0]), 0);
            end
            check("idle_ch", int'(dch[0]), t % CH);
        end

        // square region: 3 low cycles on ch0
        for (int t = 0; t < 3; t++) step(1, 0, 4'b1110, 1);
        step(1, 0, 4'hF, 1);
        advance_to(0);
        check("square_ch0", int'(dd[0]), 9);
        check("square_ch0_sat", int'(dd[1]), 9);

        // halve region: 10 low cycles on ch1
        for (int t = 0; t < 10; t++) step(1, 0, 4'b1101, 1);
        step(1, 0, 4'hF, 1);
        advance_to(1);
        check("halve_ch1", int'(dd[0]), 5);

        // walk ch2 count one increment per scan
        for (int n = 1; n <= 17; n++) begin
            step(1, 0, 4'b1011, 1);
            step(1, 0, 4'hF, 1);
            advance_to(2);
            case (n)
                4:  check("bound_4", int'(dd[0]), 16);
                5:  check("bound_5", int'(dd[0]), 2);
                16: check("bound_16", int'(dd[0]), 8);
                17: check("bound_17", int'(dd[0]), 0);
                default: ;
            endcase
        end
        step(0, 0, 4'b1011, 1);
        step(1, 0, 4'hF, 1);
        advance_to(2);
        check("en_low_hold", int'(dd[0]), 0);
        check("en_low_model", m_cnt[0][2], 17);

        // backpressure
        hch = m_ch[0];
        hd  = m_d[0];
        for (int t = 0; t < 6; t++) begin
            step(1, 0, 4'b0111, 0);
            check("bp_valid", int'(dv[0]), 1);
            check("bp_ch", int'(dch[0]), hch);
            check("bp_data", int'(dd[0]), hd);
        end
        step(1, 0, 4'hF, 1);
        check("bp_release_ch", int'(dch[0]), (hch + 1) % CH);

        // overflow
        step(1, 1, 4'hF, 1);
        for (int t = 0; t < 259; t++) step(1, 0, 4'b1110, 1'($urandom_range(0, 1)));
        check("ovf_wrap", int'(dovf[0]), 1);
        check("ovf_sat", int'(dovf[1]), 1);
        step(1, 0, 4'hF, 1);
        advance_to(0);
        check("wrap_cnt3", int'(dd[0]), 9);
        check("sat_cnt255", int'(dd[1]), 0);
        step(1, 1, 4'b1110, 1);
        check("clr_ovf_wrap", int'(dovf[0]), 0);
        check("clr_ovf_sat", int'(dovf[1]), 0);
        advance_to(0);
        check("clr_cnt0", int'(dd[0]), 0);

        // randomized traffic
        for (int t = 0; t < 500; t++) begin
            logic [CH-1:0] iv;
            for (int i = 0; i < CH; i++) iv[i] = ($urandom_range(0, 2) != 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), iv,
                 1'($urandom_range(0, 2) != 0));
        end

        // async reset between edges
        step(1, 0, 4'b0000, 1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_valid", int'(dv[0]), 0);
        check("async_ch", int'(dch[0]), 0);
        check("async_data", int'(dd[0]), 0);
        check("async_ovf", int'(dovf[0]), 0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        for (int t = 0; t < 40; t++) begin
            logic [CH-1:0] iv;
            for (int i = 0; i < CH; i++) iv[i] = 1'($urandom_range(0, 1));
            step(1, 0, iv, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
